// File: rtl/uart_rx_fifo.sv
// Purpose: small first-word-fall-through FIFO, head entry presented whenever non-empty.
// Latency: a written entry is visible at rd_dat the cycle after the write.
// Backpressure: wr_rdy drops when full unless the head is popped in the same cycle.
module uart_rx_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_vld,
  input  logic [W-1:0] wr_dat,
  output logic         wr_rdy,
  output logic         rd_vld,
  output logic [W-1:0] rd_dat,
  input  logic         rd_rdy
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_wr;
  logic          do_rd;

  assign rd_vld = (count != '0);
  assign do_rd  = rd_vld && rd_rdy;
  // A pop frees the slot in the same cycle, so a full FIFO can still take a write.
  assign wr_rdy = (count != FULL_CNT) || do_rd;
  assign do_wr  = wr_vld && wr_rdy;
  // Gate the head with valid so an empty FIFO always presents zero.
  assign rd_dat = rd_vld ? mem[rd_ptr] : '0;

  // Storage array; contents are meaningless until counted as occupied.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_dat;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// Purpose: parametrised UART receiver (sync, 3-sample vote, parity/framing check) into a FWFT FIFO.
// Latency: frame pushed at the last stop-bit decision; rx_valid rises one cycle later.
// Backpressure: rx_ready pops the head; a frame arriving at a full FIFO is dropped and flags rx_overrun.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_serial,
  input  logic                 rx_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_overrun,
  input  logic                 clr_overrun,
  output logic                 busy
);
  localparam int CPB = CLK_FREQ / BAUD_RATE;
  localparam int H   = CPB / 2;
  localparam int CW  = $clog2(CPB);
  localparam int BW  = 4;
  localparam logic [CW-1:0] C_S0  = CW'(H - 1);
  localparam logic [CW-1:0] C_S1  = CW'(H);
  localparam logic [CW-1:0] C_DEC = CW'(H + 1);
  localparam logic [CW-1:0] C_END = CW'(CPB - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  typedef struct packed {
    logic [DATA_BITS-1:0] data;
    logic                 parity_err;
    logic                 frame_err;
  } frame_t;

  state_t               state_q, state_d;
  logic [1:0]           sync_q;
  logic                 s;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bit_idx;
  logic                 smp0, smp1, maj;
  logic                 at_s0, at_s1, at_dec, at_end;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr, ferr, armed;
  logic                 push, frame_ferr, fifo_wr_rdy;
  frame_t               push_frame, head_frame;

  assign s      = sync_q[1];
  assign at_s0  = (cnt == C_S0);
  assign at_s1  = (cnt == C_S1);
  assign at_dec = (cnt == C_DEC);
  assign at_end = (cnt == C_END);
  // Third sample is the live line at the decision cycle.
  assign maj    = (smp0 & smp1) | (smp0 & s) | (smp1 & s);
  assign frame_ferr = ferr | ~maj;
  assign push_frame = '{data: shreg, parity_err: perr, frame_err: frame_ferr};
  assign busy   = (state_q != S_IDLE);

  // Two-flop synchroniser, idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx_serial};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state and push decode; the last stop bit ends the frame at its decision point.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE:   if (!s && rx_en && armed) state_d = S_START;
      S_START: begin
        if (at_dec && maj) state_d = S_IDLE;
        else if (at_end)   state_d = S_DATA;
      end
      S_DATA:   if (at_end && bit_idx == LAST_DATA) state_d = (PARITY != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (at_end) state_d = S_STOP;
      S_STOP: begin
        if (at_dec && bit_idx == LAST_STOP) begin
          state_d = S_IDLE;
          push    = 1'b1;
        end
      end
      default:  state_d = S_IDLE;
    endcase
  end

  // Bit timing, sampling, shift register, error flags and re-arm tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      bit_idx <= '0;
      smp0    <= 1'b1;
      smp1    <= 1'b1;
      shreg   <= '0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      armed   <= 1'b1;
    end else begin
      if (at_s0) smp0 <= s;
      if (at_s1) smp1 <= s;
      if (state_q == S_IDLE || state_d != state_q || at_end) cnt <= '0;
      else                                                  cnt <= cnt + CW'(1);
      case (state_q)
        S_IDLE: begin
          bit_idx <= '0;
          if (s) armed <= 1'b1;
          if (state_d == S_START) begin
            perr <= 1'b0;
            ferr <= 1'b0;
          end
        end
        S_DATA: begin
          if (at_dec) shreg <= {maj, shreg[DATA_BITS-1:1]};
          if (at_end) bit_idx <= (bit_idx == LAST_DATA) ? '0 : bit_idx + BW'(1);
        end
        S_PARITY: begin
          if (at_dec) perr <= (PARITY == 1) ? ~(^shreg ^ maj) : (^shreg ^ maj);
        end
        S_STOP: begin
          if (at_dec && !maj) ferr <= 1'b1;
          if (at_end) bit_idx <= bit_idx + BW'(1);
          // A framing error (break or stuck-low line) must see idle before the next start.
          if (push) armed <= ~frame_ferr;
        end
        default: ;
      endcase
    end
  end

  // Sticky overrun; a new drop takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    rx_overrun <= 1'b0;
    else if (push && !fifo_wr_rdy) rx_overrun <= 1'b1;
    else if (clr_overrun)          rx_overrun <= 1'b0;
  end

  uart_rx_sync_fifo #(
    .W     ($bits(frame_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_vld (push),
    .wr_dat (push_frame),
    .wr_rdy (fifo_wr_rdy),
    .rd_vld (rx_valid),
    .rd_dat (head_frame),
    .rd_rdy (rx_ready)
  );

  assign rx_data       = head_frame.data;
  assign rx_parity_err = head_frame.parity_err;
  assign rx_frame_err  = head_frame.frame_err;
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Parametrised UART receiver for the serial front end of the cipher datapath, succeeding the fixed 8N1 receiver. It adds:
- configurable data width, parity and stop bits;
- a two-flop input synchroniser and 3-sample majority voting;
- false-start rejection and per-byte parity/framing error flags;
- a small first-word-fall-through FIFO with a valid/ready output handshake and a sticky overrun flag.

Reception is gated by `rx_en`, driven from the cipher core's done/idle signal.

## Interface
- CLK_FREQ, 100000000: clock frequency, Hz.
- BAUD_RATE, 9600: line rate; CPB = CLK_FREQ/BAUD_RATE (integer divide), must be >= 8.
- DATA_BITS, 8: data bits per frame, legal 5..9.
- PARITY, 0: 0 none, 1 odd, 2 even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: entries, power of 2, >= 2.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_serial  in  1  asynchronous serial line, idle high.
- rx_en  in  1  1 = new frames may start; sampled only in IDLE.
- rx_data  out  DATA_BITS  FIFO head data, right-justified, LSB = first received bit.
- rx_parity_err  out  1  FIFO head parity error (0 when PARITY=0).
- rx_frame_err  out  1  FIFO head framing error.
- rx_valid  out  1  FIFO non-empty.
- rx_ready  in  1  consumer accepts head when rx_valid and rx_ready.
- rx_overrun  out  1  sticky: a frame was dropped because the FIFO was full.
- clr_overrun  in  1  one-cycle pulse clears rx_overrun.
- busy  out  1  FSM not in IDLE.

## Operation
- Synchroniser: two flops, both reset to 1; the FSM sees only the synchronised line `s`.
- FSM states: IDLE, START, DATA, PARITY, STOP. Every non-IDLE state runs a bit counter cnt from 0 to CPB-1.
- Sampling: with H = CPB/2, `s` is sampled at cnt = H-1, H and H+1. The bit value is the 2-of-3 majority, decided at cnt = H+1.
- IDLE -> START: when s==0, rx_en==1 and armed==1, with cnt=0.
- START, decision:
  - majority 1 = false start: go to IDLE, no push, no flags.
  - majority 0: continue to the end of the bit period, then DATA.
- DATA: DATA_BITS bits, LSB first, shifted into the assembly register.
- PARITY: entered only if PARITY != 0.
  - parity_err = 1 when the total count of ones in data + parity bit is not odd (odd mode) or not even (even mode).
- STOP: STOP_BITS bit periods. frame_err = 1 if any stop-bit majority is 0.
  - At the decision point of the last stop bit, the frame {data, parity_err, frame_err} is pushed and the FSM returns to IDLE. The rest of that bit period is not waited.
- armed: cleared when a frame ends with frame_err. Set again when IDLE sees s==1. This prevents a break or stuck-low line from generating back-to-back frames.
- rx_en is ignored outside IDLE. Dropping it mid-frame does not abort the frame.
- FIFO:
  - FWFT: rx_data and the flags are valid whenever rx_valid = 1; pop on rx_valid && rx_ready.
  - Occupancy counter is clog2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.
- Push when full with no pop in the same cycle: the new frame is discarded, FIFO contents are unchanged and rx_overrun is set.
- Push and pop in the same cycle: both take effect, occupancy is unchanged, and no overrun occurs even when full.
- clr_overrun coincident with an overrun event: set wins.

## Timing
- Reset values: busy=0, rx_valid=0, rx_overrun=0, rx_data=0, rx_parity_err=0, rx_frame_err=0, FIFO empty, armed=1, state IDLE. Reset asserted mid-frame discards the partial frame immediately.
- Start detection: 2 cycles (synchroniser) after the falling edge of rx_serial, plus 1 cycle for the IDLE->START transition.
- Push to output: rx_valid rises on the cycle after the last stop-bit decision cycle when the FIFO was empty.
- Pop: the next entry, or rx_valid=0, appears on the cycle after the pop.
- Frame duration, line falling edge to push: (1 + DATA_BITS + (PARITY!=0) + STOP_BITS - 1) * CPB + H + 1 + 3 cycles, ±1 cycle of synchroniser phase.
- busy is 1 from the cycle after start detection until the cycle the FSM re-enters IDLE.

## Test plan
- 8N1, CPB=16, rx_ready=1: send 0xA5 -> one pop, rx_data=0xA5, both error flags 0, rx_overrun=0.
- 7E1 (DATA_BITS=7, PARITY=2): send 0x55 with parity bit 1 -> rx_data=0x55, rx_parity_err=1. Repeat with parity 0 -> rx_parity_err=0.
- Framing and break: stop bit held 0, then the line stays low for 30 bit times -> exactly one entry with rx_frame_err=1. No further frames until the line returns high, then 0x3C is received cleanly.
- Glitch: rx_serial low for 3 cycles at CPB=16 -> FSM returns to IDLE, rx_valid stays 0. A one-cycle glitch at mid-data-bit is outvoted and the byte is correct.
- Overrun, FIFO_DEPTH=4, rx_ready=0: send 0x01..0x05 -> 4 entries held, rx_overrun=1.
  - Then rx_ready=1: pops 0x01..0x04 in order, 0x05 absent.
  - clr_overrun -> rx_overrun=0.
  - With the FIFO full and a pop in the push cycle -> no overrun.
- Gating and reset: rx_en=0 during a frame start -> no entry. rx_en dropped mid-frame -> byte still delivered. rst_n pulsed mid-frame -> all outputs 0, and the next full frame is received correctly.
